interrupt_sequencer: RTL and testbench

Sits directly upstream of the control state machine, between the data-bus opcode path and the instruction decoder. At every instruction boundary it decides whether to execute the fetched opcode or inject the BRK opcode (8'h00) to start a RESET, NMI or IRQ sequence. It synchronises the external interrupt pins, edge-detects NMI, and holds per-source pending flags. It latches the serviced interrupt type so the BRK microcode can select the vector, the pushed B-flag value and stack-write suppression.

---
 rtl/interrupt_sequencer_pkg.sv | 34 +++
 rtl/interrupt_sequencer_if.sv | 36 +++
 rtl/interrupt_sequencer_pin_synchronizer.sv | 33 +++
 rtl/interrupt_sequencer.sv | 120 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_pkg
// Shared types and constants for the interrupt sequencer:
//   - int_type_e : type of the hardware sequence in progress (NONE/RESET/NMI/IRQ)
//   - VEC_*_LO   : low byte of the vector address for each sequence type
//   - vector_low_for() : maps a sequence type to its vector low byte
// -----------------------------------------------------------------------------
package interrupt_sequencer_pkg;

    typedef enum logic [1:0] {
        INT_NONE  = 2'd0,
        INT_RESET = 2'd1,
        INT_NMI   = 2'd2,
        INT_IRQ   = 2'd3
    } int_type_e;

    localparam logic [7:0] VEC_NMI_LO   = 8'hFA;
    localparam logic [7:0] VEC_RESET_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO   = 8'hFE;

    // A software BRK (NONE) shares the IRQ vector.
    function automatic logic [7:0] vector_low_for(input int_type_e t);
        logic [7:0] v;
        case (t)
            INT_RESET: v = VEC_RESET_LO;
            INT_NMI:   v = VEC_NMI_LO;
            INT_IRQ:   v = VEC_IRQ_LO;
            INT_NONE:  v = VEC_IRQ_LO;
            default:   v = VEC_IRQ_LO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_if
// Opcode-path and sequence-status bundle between the state machine side
// (master) and the interrupt sequencer (slave).
//   getInstruction : instruction-boundary strobe
//   enableFFs      : global stall, low freezes sequencer state
//   opcodeIn       : byte currently on the data bus
//   opcodeOut      : byte presented to the decoder
//   intType        : latched type of the sequence in progress
//   vectorLow      : vector low byte for the sequence in progress
//   bFlagPush      : B-bit value for the pushed status
//   suppressWrite  : stack pushes become reads (RESET sequence)
// -----------------------------------------------------------------------------
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    logic       getInstruction;
    logic       enableFFs;
    logic [7:0] opcodeIn;
    logic [7:0] opcodeOut;
    int_type_e  intType;
    logic [7:0] vectorLow;
    logic       bFlagPush;
    logic       suppressWrite;

    modport master (
        output getInstruction, enableFFs, opcodeIn,
        input  opcodeOut, intType, vectorLow, bFlagPush, suppressWrite
    );

    modport slave (
        input  getInstruction, enableFFs, opcodeIn,
        output opcodeOut, intType, vectorLow, bFlagPush, suppressWrite
    );

endinterface

// File: rtl/interrupt_sequencer_pin_synchronizer.sv
// -----------------------------------------------------------------------------
// pin_synchronizer
// Two-flop synchroniser for an asynchronous active-low pin. Resets to 1
// (pin inactive) and runs every cycle; it has no stall input on purpose.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   i_async : asynchronous pin
//   o_sync  : synchronised pin
// -----------------------------------------------------------------------------
module pin_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage synchronisation of the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
// Decides at each instruction boundary whether the fetched opcode executes or
// BRK is injected to start a RESET, NMI or IRQ sequence, and latches the
// serviced type for the BRK microcode.
//   clk, rst   : clock and synchronous active-high reset
//   nNMI, nIRQ : asynchronous active-low interrupt pins (NMI edge, IRQ level)
//   iFlag      : processor-status interrupt-disable bit
//   bus        : opcode path and sequence status (see interrupt_sequencer_if)
// -----------------------------------------------------------------------------
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [7:0] BRK_OPCODE = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nNMI,
    input  logic                  nIRQ,
    input  logic                  iFlag,
    interrupt_sequencer_if.slave  bus
);

    logic      w_nmi_sync;
    logic      w_irq_sync;
    logic      w_nmi_edge;
    logic      w_irq_active;
    logic      w_take;
    int_type_e w_sel;

    logic      r_nmi_prev;
    logic      r_reset_pending;
    logic      r_nmi_pending;
    int_type_e r_int_type;
    logic [7:0] r_vector_low;
    logic      r_b_flag_push;
    logic      r_suppress_write;

    pin_synchronizer u_nmi_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (nNMI),
        .o_sync  (w_nmi_sync)
    );

    pin_synchronizer u_irq_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (nIRQ),
        .o_sync  (w_irq_sync)
    );

    assign w_nmi_edge   = r_nmi_prev & ~w_nmi_sync;
    assign w_irq_active = ~w_irq_sync & ~iFlag;
    assign w_take       = bus.getInstruction & bus.enableFFs;

    // Priority selection RESET > NMI > IRQ; IRQ is level-only with no latch.
    always_comb begin
        w_sel = INT_NONE;
        if (r_reset_pending) begin
            w_sel = INT_RESET;
        end else if (r_nmi_pending) begin
            w_sel = INT_NMI;
        end else if (w_irq_active) begin
            w_sel = INT_IRQ;
        end else begin
            w_sel = INT_NONE;
        end
    end

    // Injection ignores enableFFs so the decoder view is stable during a stall.
    assign bus.opcodeOut = (bus.getInstruction && (w_sel != INT_NONE)) ? BRK_OPCODE : bus.opcodeIn;

    // Previous synchronised NMI level; tracks every cycle, even when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_prev <= 1'b1;
        end else begin
            r_nmi_prev <= w_nmi_sync;
        end
    end

    // Pending flags; an NMI edge sets even during a stall and wins over service.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reset_pending <= 1'b1;
            r_nmi_pending   <= 1'b0;
        end else begin
            if (w_take && (w_sel == INT_RESET)) begin
                r_reset_pending <= 1'b0;
            end
            if (w_nmi_edge) begin
                r_nmi_pending <= 1'b1;
            end else if (w_take && (w_sel == INT_NMI)) begin
                r_nmi_pending <= 1'b0;
            end
        end
    end

    // Latched sequence type and its derived microcode controls, updated at take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_type       <= INT_NONE;
            r_vector_low     <= VEC_IRQ_LO;
            r_b_flag_push    <= 1'b1;
            r_suppress_write <= 1'b0;
        end else if (w_take) begin
            r_int_type       <= w_sel;
            r_vector_low     <= vector_low_for(w_sel);
            r_b_flag_push    <= (w_sel == INT_NONE);
            r_suppress_write <= (w_sel == INT_RESET);
        end
    end

    assign bus.intType       = r_int_type;
    assign bus.vectorLow     = r_vector_low;
    assign bus.bFlagPush     = r_b_flag_push;
    assign bus.suppressWrite = r_suppress_write;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
// Directed self-checking bench for interrupt_sequencer.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;
    import interrupt_sequencer_pkg::*;

    logic clk;
    logic rst;
    logic nNMI;
    logic nIRQ;
    logic iFlag;

    int n_checks;
    int n_errors;

    interrupt_sequencer_if bus ();

    interrupt_sequencer #(.BRK_OPCODE(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .nNMI  (nNMI),
        .nIRQ  (nIRQ),
        .iFlag (iFlag),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a boundary with the given bus byte and let the logic settle.
    task automatic boundary(input logic [7:0] op);
        bus.getInstruction = 1'b1;
        bus.opcodeIn       = op;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcodeIn = 8'h5A;
        step(3);
        n_checks++;
        if (bus.intType !== INT_NONE) begin
            n_errors++; $display("FAIL rst_intType: got %0d expected %0d", bus.intType, INT_NONE);
        end
        n_checks++;
        if (bus.vectorLow !== 8'hFE) begin
            n_errors++; $display("FAIL rst_vectorLow: got %h expected fe", bus.vectorLow);
        end
        n_checks++;
        if (bus.bFlagPush !== 1'b1 || bus.suppressWrite !== 1'b0) begin
            n_errors++; $display("FAIL rst_flags: got b=%b s=%b expected b=1 s=0", bus.bFlagPush, bus.suppressWrite);
        end
        n_checks++;
        if (bus.opcodeOut !== 8'h5A) begin
            n_errors++; $display("FAIL rst_opcode_pass: got %h expected 5a", bus.opcodeOut);
        end
        rst = 1'b0;
        boundary(8'hA9);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL reset_inject: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        #1;
        n_checks++;
        if (bus.intType !== INT_RESET || bus.vectorLow !== 8'hFC) begin
            n_errors++; $display("FAIL reset_type: got %0d/%h expected 1/fc", bus.intType, bus.vectorLow);
        end
        n_checks++;
        if (bus.suppressWrite !== 1'b1 || bus.bFlagPush !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: got s=%b b=%b expected s=1 b=0", bus.suppressWrite, bus.bFlagPush);
        end
        n_checks++;
        if (bus.opcodeOut !== 8'hA9) begin
            n_errors++; $display("FAIL reset_cleared: got %h expected a9", bus.opcodeOut);
        end
    endtask

    task automatic test_nmi();
        nNMI = 1'b0;
        step(5);
        boundary(8'hEA);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL nmi_inject: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_NMI || bus.vectorLow !== 8'hFA) begin
            n_errors++; $display("FAIL nmi_type: got %0d/%h expected 2/fa", bus.intType, bus.vectorLow);
        end
        n_checks++;
        if (bus.bFlagPush !== 1'b0 || bus.suppressWrite !== 1'b0) begin
            n_errors++; $display("FAIL nmi_flags: got b=%b s=%b expected b=0 s=0", bus.bFlagPush, bus.suppressWrite);
        end
        // nNMI held low: level must not retrigger.
        step(3);
        boundary(8'hEA);
        n_checks++;
        if (bus.opcodeOut !== 8'hEA) begin
            n_errors++; $display("FAIL nmi_level_no_retrigger: got %h expected ea", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_NONE) begin
            n_errors++; $display("FAIL nmi_second_type: got %0d expected 0", bus.intType);
        end
        nNMI = 1'b1;
        step(3);
    endtask

    task automatic test_irq();
        nIRQ  = 1'b0;
        iFlag = 1'b1;
        step(3);
        boundary(8'h4C);
        n_checks++;
        if (bus.opcodeOut !== 8'h4C) begin
            n_errors++; $display("FAIL irq_masked_pass: got %h expected 4c", bus.opcodeOut);
        end
        step(1);
        n_checks++;
        if (bus.intType !== INT_NONE) begin
            n_errors++; $display("FAIL irq_masked_type: got %0d expected 0", bus.intType);
        end
        iFlag = 1'b0;
        boundary(8'h4C);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL irq_inject: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_IRQ || bus.vectorLow !== 8'hFE || bus.bFlagPush !== 1'b0) begin
            n_errors++; $display("FAIL irq_type: got %0d/%h/%b expected 3/fe/0", bus.intType, bus.vectorLow, bus.bFlagPush);
        end
        nIRQ  = 1'b1;
        iFlag = 1'b1;
        step(3);
    endtask

    task automatic test_priority();
        nNMI  = 1'b0;
        nIRQ  = 1'b0;
        iFlag = 1'b0;
        step(4);
        boundary(8'h6C);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL prio_inject1: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        n_checks++;
        if (bus.intType !== INT_NMI) begin
            n_errors++; $display("FAIL prio_nmi_first: got %0d expected 2", bus.intType);
        end
        // Back-to-back boundary: IRQ still asserted.
        boundary(8'h6C);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL prio_inject2: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_IRQ || bus.vectorLow !== 8'hFE) begin
            n_errors++; $display("FAIL prio_irq_second: got %0d/%h expected 3/fe", bus.intType, bus.vectorLow);
        end
        nNMI  = 1'b1;
        nIRQ  = 1'b1;
        iFlag = 1'b1;
        step(3);
    endtask

    task automatic test_stall();
        bus.enableFFs = 1'b0;
        nNMI = 1'b0;
        boundary(8'hEA);
        step(1);
        n_checks++;
        if (bus.opcodeOut !== 8'hEA) begin
            n_errors++; $display("FAIL stall_pre_edge: got %h expected ea", bus.opcodeOut);
        end
        step(3);
        n_checks++;
        if (bus.intType !== INT_IRQ) begin
            n_errors++; $display("FAIL stall_hold_type: got %0d expected 3", bus.intType);
        end
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL stall_nmi_pending_view: got %h expected 00", bus.opcodeOut);
        end
        nNMI = 1'b1;
        bus.enableFFs = 1'b1;
        #1;
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_NMI || bus.vectorLow !== 8'hFA) begin
            n_errors++; $display("FAIL stall_nmi_serviced: got %0d/%h expected 2/fa", bus.intType, bus.vectorLow);
        end
        step(3);
    endtask

    task automatic test_soft_brk_and_reset();
        boundary(8'h00);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL swbrk_opcode: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_NONE || bus.vectorLow !== 8'hFE || bus.bFlagPush !== 1'b1 || bus.suppressWrite !== 1'b0) begin
            n_errors++; $display("FAIL swbrk_status: got %0d/%h/%b/%b expected 0/fe/1/0",
                                 bus.intType, bus.vectorLow, bus.bFlagPush, bus.suppressWrite);
        end
        // Start an IRQ sequence, then reset in the middle of it.
        nIRQ  = 1'b0;
        iFlag = 1'b0;
        step(3);
        boundary(8'h20);
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_IRQ) begin
            n_errors++; $display("FAIL midrst_pre: got %0d expected 3", bus.intType);
        end
        rst   = 1'b1;
        nIRQ  = 1'b1;
        iFlag = 1'b1;
        step(1);
        n_checks++;
        if (bus.intType !== INT_NONE || bus.suppressWrite !== 1'b0) begin
            n_errors++; $display("FAIL midrst_clear: got %0d/%b expected 0/0", bus.intType, bus.suppressWrite);
        end
        rst = 1'b0;
        step(1);
        boundary(8'hA9);
        n_checks++;
        if (bus.opcodeOut !== 8'h00) begin
            n_errors++; $display("FAIL midrst_inject: got %h expected 00", bus.opcodeOut);
        end
        step(1);
        bus.getInstruction = 1'b0;
        n_checks++;
        if (bus.intType !== INT_RESET || bus.vectorLow !== 8'hFC || bus.suppressWrite !== 1'b1) begin
            n_errors++; $display("FAIL midrst_reset_type: got %0d/%h/%b expected 1/fc/1",
                                 bus.intType, bus.vectorLow, bus.suppressWrite);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        nNMI  = 1'b1;
        nIRQ  = 1'b1;
        iFlag = 1'b1;
        bus.getInstruction = 1'b0;
        bus.enableFFs      = 1'b1;
        bus.opcodeIn       = 8'h00;

        test_reset();
        test_nmi();
        test_irq();
        test_priority();
        test_stall();
        test_soft_brk_and_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
